// File: rtl/spn_round_engine.sv
// Iterative 16-bit SPN cipher that walks each block nibble-by-nibble through an external S-box.
// Latency 6*ROUNDS+1 edges from accept to out_valid. One block in flight; in_ready stays low until out_ready takes the result.

module spn_round_engine #(
    parameter int unsigned ROUNDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] data_in,
    input  logic [15:0] key_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] data_out,
    output logic [3:0]  sbox_in,
    input  logic [3:0]  sbox_out,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_XOR   = 3'd1,
        S_SUB   = 3'd2,
        S_PERM  = 3'd3,
        S_FINAL = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam logic [3:0] LAST_RND = 4'(ROUNDS);

    state_e      fsm_q, fsm_d;
    logic [15:0] blk_q, blk_d;
    logic [15:0] key_q, key_d;
    logic [15:0] dout_q, dout_d;
    logic [3:0]  rnd_q, rnd_d;
    logic [1:0]  nib_q, nib_d;
    logic [3:0]  cur_nib;

    // Rotating a doubled copy makes the wrap-around fall out of a plain shift.
    function automatic logic [15:0] rotl16(input logic [15:0] v, input logic [3:0] amt);
        logic [31:0] dbl;
        dbl = {v, v} << amt;
        return dbl[31:16];
    endfunction

    function automatic logic [15:0] permute(input logic [15:0] v);
        logic [15:0] p;
        p[15] = v[15];
        for (int i = 0; i < 15; i++) begin
            p[(4 * i) % 15] = v[i];
        end
        return p;
    endfunction

    assign cur_nib  = blk_q[{nib_q, 2'b00} +: 4];
    assign data_out = dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= S_IDLE;
            blk_q  <= '0;
            key_q  <= '0;
            dout_q <= '0;
            rnd_q  <= '0;
            nib_q  <= '0;
        end else begin
            fsm_q  <= fsm_d;
            blk_q  <= blk_d;
            key_q  <= key_d;
            dout_q <= dout_d;
            rnd_q  <= rnd_d;
            nib_q  <= nib_d;
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        blk_d     = blk_q;
        key_d     = key_q;
        dout_d    = dout_q;
        rnd_d     = rnd_q;
        nib_d     = nib_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        sbox_in   = 4'h0;

        unique case (fsm_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    blk_d = data_in;
                    key_d = key_in;
                    rnd_d = 4'd0;
                    nib_d = 2'd0;
                    fsm_d = S_XOR;
                end
            end
            S_XOR: begin
                blk_d = blk_q ^ rotl16(key_q, rnd_q);
                nib_d = 2'd0;
                fsm_d = S_SUB;
            end
            S_SUB: begin
                // The S-box answers combinationally, so the nibble is replaced at this edge.
                sbox_in                      = cur_nib;
                blk_d[{nib_q, 2'b00} +: 4]   = sbox_out;
                nib_d                        = nib_q + 2'd1;
                if (nib_q == 2'd3) begin
                    fsm_d = S_PERM;
                end
            end
            S_PERM: begin
                blk_d = permute(blk_q);
                rnd_d = rnd_q + 4'd1;
                fsm_d = (rnd_d == LAST_RND) ? S_FINAL : S_XOR;
            end
            S_FINAL: begin
                dout_d = blk_q ^ rotl16(key_q, LAST_RND);
                fsm_d  = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

endmodule
